// File: rtl/sum_window_acc.sv
// sum_window_acc: accumulates COUNT unsigned samples (or a flushed partial
// window) into a total and presents it on a valid/ready result port along
// with the sample count and a sticky carry-out flag.
module sum_window_acc #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned COUNT     = 4,
  parameter int unsigned ACC_WIDTH = 10,
  parameter int unsigned CW        = $clog2(COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [CW-1:0]        out_count,
  output logic                 out_ovf
);

  localparam int unsigned SW = ACC_WIDTH + 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [ACC_WIDTH-1:0] acc;
  logic [CW-1:0]        cnt;
  logic                 ovf;

  logic [SW-1:0]        sum_ext;
  logic [ACC_WIDTH-1:0] acc_nxt;
  logic [CW-1:0]        cnt_nxt;
  logic                 ovf_nxt;
  logic                 accept;
  logic                 close;
  logic                 out_fire;

  // Ready depends only on the state register, never on out_ready.
  assign in_ready = (state == ACCUM);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus the window arithmetic including any same-cycle sample.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    close     = 1'b0;
    out_fire  = 1'b0;
    sum_ext   = {1'b0, acc} + SW'(in_data);
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    case (state)
      ACCUM: begin
        accept = in_valid;
        if (accept) begin
          acc_nxt = sum_ext[ACC_WIDTH-1:0];
          cnt_nxt = cnt + CW'(1);
          ovf_nxt = ovf | sum_ext[ACC_WIDTH];
        end
        // Close on the COUNT-th sample, or on a flush with something to report.
        if ((accept && (cnt_nxt == CW'(COUNT))) || (flush && (cnt_nxt != '0))) begin
          close     = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_fire = out_valid && out_ready;
        if (out_fire) begin
          state_nxt = ACCUM;
        end
      end
      default: begin
        state_nxt = ACCUM;
      end
    endcase
  end

  // Running window accumulator, count and sticky carry flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (close) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
    end
  end

  // Result register: loaded on close, held through backpressure and after release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (close) begin
      out_valid <= 1'b1;
      out_data  <= acc_nxt;
      out_count <= cnt_nxt;
      out_ovf   <= ovf_nxt;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_window_acc.sv
// Scoreboard bench for sum_window_acc: two instances (ACC_WIDTH 10 and 9)
// share one stimulus stream; each window's expected result is queued by the
// stimulus and checked by an independent monitor when out_valid rises.
module tb_sum_window_acc;

  logic       clk;
  logic       rstn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       flush;
  logic       out_ready;

  logic       in_ready_a, in_ready_b;
  logic       out_valid_a, out_valid_b;
  logic [9:0] out_data_a;
  logic [8:0] out_data_b;
  logic [2:0] out_count_a, out_count_b;
  logic       out_ovf_a, out_ovf_b;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [9:0] d10;
    logic       o10;
    logic [8:0] d9;
    logic       o9;
    logic [2:0] cnt;
  } exp_t;

  exp_t q[$];

  sum_window_acc #(.WIDTH(8), .COUNT(4), .ACC_WIDTH(10)) dut_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .flush(flush), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_count(out_count_a),
    .out_ovf(out_ovf_a)
  );

  sum_window_acc #(.WIDTH(8), .COUNT(4), .ACC_WIDTH(9)) dut_b (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .flush(flush), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_count(out_count_b),
    .out_ovf(out_ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [9:0] d10, input logic o10, input logic [8:0] d9,
                      input logic o9, input logic [2:0] c);
    exp_t e;
    e.d10 = d10; e.o10 = o10; e.d9 = d9; e.o9 = o9; e.cnt = c;
    q.push_back(e);
  endtask

  // Present a sample (optionally with flush) until accepted; called just after a posedge.
  task automatic send(input logic [7:0] v, input logic fl);
    logic rdy;
    logic got;
    got = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    flush    = fl;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      rdy = in_ready_a;
      @(posedge clk);
      if (rdy) got = 1'b1;
    end
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    if (!got) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush_only();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  // Monitor: pop on each new result, then require it to stay stable while valid.
  exp_t       cur;
  logic       prev_valid = 1'b0;
  logic [9:0] h_d10;
  logic [8:0] h_d9;
  logic [2:0] h_ca, h_cb;
  logic       h_oa, h_ob;

  always @(negedge clk) begin
    if (out_valid_a !== out_valid_b) chk("valid_agree", 32'(out_valid_b), 32'(out_valid_a));
    if (out_valid_a === 1'b1 && !prev_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        cur = q.pop_front();
        chk("out_data_10", 32'(out_data_a), 32'(cur.d10));
        chk("out_ovf_10", 32'(out_ovf_a), 32'(cur.o10));
        chk("out_count_10", 32'(out_count_a), 32'(cur.cnt));
        chk("out_data_9", 32'(out_data_b), 32'(cur.d9));
        chk("out_ovf_9", 32'(out_ovf_b), 32'(cur.o9));
        chk("out_count_9", 32'(out_count_b), 32'(cur.cnt));
      end
      h_d10 = out_data_a; h_d9 = out_data_b;
      h_ca = out_count_a; h_cb = out_count_b;
      h_oa = out_ovf_a;   h_ob = out_ovf_b;
    end else if (out_valid_a === 1'b1 && prev_valid) begin
      chk("hold_data_10", 32'(out_data_a), 32'(h_d10));
      chk("hold_data_9", 32'(out_data_b), 32'(h_d9));
      chk("hold_count", 32'({out_count_a, out_count_b}), 32'({h_ca, h_cb}));
      chk("hold_ovf", 32'({out_ovf_a, out_ovf_b}), 32'({h_oa, h_ob}));
    end
    prev_valid = (out_valid_a === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("rst_out_valid", 32'({out_valid_a, out_valid_b}), 32'd0);
    chk("rst_in_ready", 32'({in_ready_a, in_ready_b}), 32'd3);
    chk("rst_out_data", 32'({out_data_a, out_data_b}), 32'd0);
    chk("rst_count_ovf", 32'({out_count_a, out_count_b, out_ovf_a, out_ovf_b}), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Full window, back-to-back, sink always ready.
    push(10'd335, 1'b0, 9'd335, 1'b0, 3'd4);
    send(8'd25, 1'b0); send(8'd55, 1'b0); send(8'd0, 1'b0); send(8'd255, 1'b0);
    @(negedge clk);
    chk("t1_hold_in_ready", 32'({in_ready_a, in_ready_b}), 32'd0);
    chk("t1_out_valid_up", 32'(out_valid_a), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_in_ready_back", 32'({in_ready_a, in_ready_b}), 32'd3);
    chk("t1_out_valid_down", 32'(out_valid_a), 32'd0);
    @(posedge clk); #1;

    // Backpressure: result held 5 cycles while a sample of 7 waits upstream.
    out_ready = 1'b0;
    push(10'd335, 1'b0, 9'd335, 1'b0, 3'd4);
    send(8'd25, 1'b0); send(8'd55, 1'b0); send(8'd0, 1'b0); send(8'd255, 1'b0);
    in_valid = 1'b1; in_data = 8'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_stall_ready", 32'(in_ready_a), 32'd0);
      chk("t2_stall_valid", 32'(out_valid_a), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(10'd28, 1'b0, 9'd28, 1'b0, 3'd4);
    send(8'd7, 1'b0); send(8'd7, 1'b0); send(8'd7, 1'b0); send(8'd7, 1'b0);

    // Partial window closed by flush with a same-cycle sample, then an empty flush.
    push(10'd55, 1'b0, 9'd55, 1'b0, 3'd3);
    send(8'd15, 1'b0); send(8'd10, 1'b0); send(8'd30, 1'b1);
    idle(3);
    flush_only();
    idle(5);
    @(negedge clk);
    chk("t3_empty_flush_ready", 32'(in_ready_a), 32'd1);
    chk("t3_empty_flush_valid", 32'(out_valid_a), 32'd0);
    @(posedge clk); #1;
    // Flush of a single already-accepted sample.
    push(10'd5, 1'b0, 9'd5, 1'b0, 3'd1);
    send(8'd5, 1'b0);
    flush_only();
    idle(3);

    // Overflow: 766 wraps to 254 at 9 bits; next window clears the flag.
    push(10'd766, 1'b0, 9'd254, 1'b1, 3'd4);
    send(8'd255, 1'b0); send(8'd255, 1'b0); send(8'd255, 1'b0); send(8'd1, 1'b0);
    push(10'd4, 1'b0, 9'd4, 1'b0, 3'd4);
    send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0);
    idle(3);

    // Reset mid-window, asserted between edges.
    send(8'd2, 1'b0); send(8'd2, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("t5_rst_valid", 32'({out_valid_a, out_valid_b}), 32'd0);
    chk("t5_rst_ready", 32'({in_ready_a, in_ready_b}), 32'd3);
    chk("t5_rst_data", 32'({out_data_a, out_data_b}), 32'd0);
    chk("t5_rst_count_ovf", 32'({out_count_a, out_count_b, out_ovf_a, out_ovf_b}), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    push(10'd4, 1'b0, 9'd4, 1'b0, 3'd4);
    send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0);
    idle(3);

    // Reset while a result is held: it must vanish and never be handshaken.
    out_ready = 1'b0;
    push(10'd6, 1'b0, 9'd6, 1'b0, 3'd3);
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b1);
    @(negedge clk);
    chk("t6_hold_valid", 32'(out_valid_a), 32'd1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_valid", 32'({out_valid_a, out_valid_b}), 32'd0);
    chk("t6_rst_ready", 32'({in_ready_a, in_ready_b}), 32'd3);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(10);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sum_window_acc.md
# sum_window_acc

Downstream consumer of the registered adder output. Accepts one `WIDTH`-bit sum per valid/ready handshake and accumulates `COUNT` samples into a window total. Presents that total on a valid/ready output port, together with a sample count and an overflow flag. Sits between the adder stage and the result sink/monitor.

## Interface
- `WIDTH`, 8, input sample width; matches the adder `WIDTH`.
- `COUNT`, 4, samples per full window; must be ≥ 1.
- `ACC_WIDTH`, 10, accumulator/output width; must be ≥ `WIDTH`.
- `CW`, `$clog2(COUNT+1)`, derived width of `out_count`; not overridden.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rstn`  input  1  reset; asynchronous and active-low.
- `in_valid`  input  1  `in_data` carries a sample.
- `in_ready`  output  1  block can accept a sample this cycle.
- `in_data`  input  `WIDTH`  unsigned sample (adder `sum`).
- `flush`  input  1  close the current partial window early.
- `out_valid`  output  1  window result held on the out_* ports.
- `out_ready`  input  1  sink accepts the result.
- `out_data`  output  `ACC_WIDTH`  window total, modulo 2^`ACC_WIDTH`.
- `out_count`  output  `CW`  samples in the window, 1..`COUNT`.
- `out_ovf`  output  1  a carry out of `ACC_WIDTH` occurred during the window.

## Operation
- **FSM.** Two states: `ACCUM` and `HOLD`. Reset state is `ACCUM`.
- **Reset values.** `acc`=0, `cnt`=0, `ovf`=0, `out_valid`=0, `out_data`=0, `out_count`=0, `out_ovf`=0.
- **in_ready.** Equals (state == `ACCUM`). It is combinational from the state register and reads 1 after reset.
- **Accept.** `in_valid && in_ready`. On accept:
  - `acc <= acc + zext(in_data)`, truncated to `ACC_WIDTH`.
  - `cnt <= cnt+1`.
  - `ovf` is set if the unsigned add produces a carry out of bit `ACC_WIDTH-1`.
  - `ovf` is sticky for the window.
- **Window close.** Occurs in `ACCUM` on either of:
  - the accept that makes `cnt` reach `COUNT`, or
  - `flush` with an effective count ≥ 1. Effective count is `cnt` plus 1 if a sample is accepted that cycle.
- **On close:**
  - Latch the final `acc`, count and `ovf` (including any same-cycle sample) into `out_data`, `out_count` and `out_ovf`.
  - Set `out_valid`=1.
  - Clear `acc`, `cnt` and `ovf`.
  - Go to `HOLD`.
- **Empty flush.** `flush` in `ACCUM` with effective count 0 is ignored: no output, no state change.
- **flush in HOLD.** Ignored.
- **HOLD.**
  - `in_ready`=0. `out_data`, `out_count` and `out_ovf` are stable while `out_valid`=1.
  - On `out_valid && out_ready`: `out_valid <= 0`, next state is `ACCUM`.
  - `out_data`, `out_count` and `out_ovf` retain their last value after the handshake.
- **Input while not ready.** `in_valid` while `in_ready`=0 is not consumed. The upstream holds the sample.
- **Reset mid-window.** Asserting `rstn` low at any time immediately forces the reset values and `ACCUM`. Any partial window or pending output is discarded.

## Timing
- **Output latency.** `out_valid` rises on the clock edge that accepts the closing sample (or the edge where a non-empty flush is sampled). It is visible in the following cycle.
- **out_ready.** Not required in advance. `out_valid` never depends combinationally on `out_ready`.
- **Turnaround.** Output handshake at edge N → `in_ready`=1 from edge N onward, so the first accept of the next window is possible at edge N+1.
- **Throughput.** Minimum `COUNT`+1 cycles per full window (one mandatory `HOLD` cycle). Backpressure extends `HOLD` indefinitely.
- **Paths.** No combinational path from `in_*` to `out_*`, or from `out_ready` to `in_ready`.

## Test plan
- **Full window, defaults.**
  - Stimulus: reset, then accept 25, 55, 0, 255 back-to-back, `out_ready`=1.
  - Required: `out_valid` one cycle after the 4th accept; `out_data`=335, `out_count`=4, `out_ovf`=0. `in_ready` is 0 for exactly one cycle, then 1.
- **Backpressure.**
  - Stimulus: as above with `out_ready`=0 for 5 cycles; keep `in_valid`=1 with value 7.
  - Required: outputs stable for all 5 cycles; no sample is consumed; after the handshake the next window accepts 7.
- **Partial flush.**
  - Stimulus: accept 15, 10; then `flush` together with `in_valid` carrying 30.
  - Required: `out_data`=55, `out_count`=3. A later `flush` with no samples and no `in_valid` produces no `out_valid`.
- **Overflow, `ACC_WIDTH`=9.**
  - Stimulus: accept 255, 255, 255, 1.
  - Required: `out_data`=254 (766 mod 512), `out_ovf`=1. The next window of 1, 1, 1, 1 gives 4 with `out_ovf`=0, showing the flag clears per window.
- **Reset mid-operation.**
  - Stimulus: accept 2 samples, drop `rstn` asynchronously between edges.
  - Required: all outputs at their reset values immediately. After release, 4 samples of 1 give `out_data`=4, `out_count`=4.
- **Reset in HOLD.**
  - Stimulus: assert reset while `out_valid`=1.
  - Required: `out_valid`=0 at once, `in_ready`=1, the pending result is never delivered.
